sim_mem_arbiter: RTL and testbench
==================================

// Module: sim_mem_arbiter
// PURPOSE
//  Shares a single RAMHelper port between the core's icache and dcache command/response interfaces.
//  Sits in SimTop between DandRiscvSimple and one RAMHelper instance, replacing the split i/d RAM wiring.
//  Grants one command per cycle, translates byte addresses to 64-bit word indices and expands strobes.
//  Returns read data one cycle after grant on the owning requester's response channel.
// PARAMETERS
//  MEM_BASE     64'h8000_0000  byte address mapped to RAM word index 0
//  IDX_W        28             RAM word-index width (rIdx/wIdx)
//  MAX_D_BURST  4              consecutive dcache grants allowed while icache waits (>=1)
// PORTS
//  clock          in   1   system clock
//  reset          in   1   synchronous, active-high reset
//  i_cmd_valid    in   1   icache fetch request
//  i_cmd_ready    out  1   icache request accepted this cycle
//  i_cmd_addr     in   64  fetch byte address (4-byte aligned)
//  i_rsp_valid    out  1   fetch data valid
//  i_rsp_data     out  32  instruction word
//  d_cmd_valid    in   1   dcache request
//  d_cmd_ready    out  1   dcache request accepted this cycle
//  d_cmd_addr     in   64  data byte address
//  d_cmd_wen      in   1   1 = store, 0 = load
//  d_cmd_wdata    in   64  store data, lane-aligned to the 64-bit word
//  d_cmd_wstrb    in   8   store byte strobes
//  d_cmd_size     in   3   access size, log2 bytes (informational; not used for masking)
//  d_rsp_valid    out  1   load data valid (never asserted for stores)
//  d_rsp_data     out  64  full 64-bit word; the core extracts lanes
//  ram_en         out  1   RAM access enable
//  ram_idx        out  IDX_W  word index, drives both rIdx and wIdx
//  ram_rdata      in   64  RAM read data, valid in the same cycle as ram_en
//  ram_wdata      out  64  write data
//  ram_wmask      out  64  bit mask, each wstrb bit replicated x8
//  ram_wen        out  1   RAM write enable
//  err_addr       out  1   sticky flag: a request was accepted with an address below MEM_BASE
// BEHAVIOUR
//  Reset values: all outputs 0; last_grant = D; burst_cnt = 0; err_addr = 0.
//  Arbitration (combinational, one grant per cycle):
//   - Only d valid -> grant D. Only i valid -> grant I.
//   - Both valid -> grant D, unless burst_cnt == MAX_D_BURST, then grant I.
//  burst_cnt counts D grants made while i_cmd_valid is high; saturates at MAX_D_BURST; clears on any I grant or when i_cmd_valid is low.
//  ready = grant; ready may depend on valid; requesters must not make valid depend on ready.
//  Command stays stable while valid && !ready; the arbiter samples it only at the granted cycle.
//  Granted cycle: ram_en = 1; ram_idx = (addr - MEM_BASE) >> 3, truncated to IDX_W.
//   ram_wen = grant D && d_cmd_wen; icache grants never write.
//  Response latency is exactly 1 cycle after grant; there is no response backpressure.
//   - I grant: i_rsp_data <= ram_rdata[32*addr[2] +: 32]; i_rsp_valid <= 1.
//   - D load grant: d_rsp_data <= ram_rdata; d_rsp_valid <= 1.
//   - D store grant: no response; rsp_valid stays 0.
//   - Data registers hold their value when the corresponding rsp_valid is 0.
//  Back-to-back grants are permitted: one grant per cycle with 100% throughput, responses pipelined.
//  addr < MEM_BASE: the request is still accepted (ready = 1), ram_en = 0, the response (if a read) returns data 0, err_addr <= 1.
//  Reset asserted mid-operation: any pending response is dropped (rsp_valid = 0 in the next cycle) and the arbiter state returns to reset values.
// STRUCTURE
//  Shared package sim_mem_pkg:
//   - MEM_BASE constant
//   - grant_e enum {GNT_NONE, GNT_I, GNT_D}
//   - function strb2mask(8) -> 64
//  Sub-module sim_mem_grant: 2-way arbiter holding burst_cnt and last_grant, outputs grant_e.
//  Top level holds address translation, RAM drive, and response registers.
// TESTING
//  1. i-only read at 0x8000_0004, ram_rdata=64'hAAAA_BBBB_CCCC_DDDD -> idx 0, next cycle i_rsp_valid=1, data 32'hAAAA_BBBB.
//  2. d store at 0x8000_0010, wstrb=8'h0F, wdata=64'h1122_3344_5566_7788 -> ram_wen=1, idx 2, wmask=64'h0000_0000_FFFF_FFFF, no d_rsp_valid.
//  3. Both valid continuously, MAX_D_BURST=4 -> grant sequence D,D,D,D,I,D,D,D,D,I; each i stall is exactly 4 cycles.
//  4. Back-to-back d loads at 0x8000_0000 then 0x8000_0008 -> d_rsp_valid high 2 consecutive cycles, in order, with idx 0 then 1.
//  5. d load at 0x7FFF_FFF8 -> ram_en=0, d_rsp_valid=1 with data 0, err_addr=1 and stays 1 until reset.
//  6. Reset asserted the cycle after an i grant -> i_rsp_valid=0 next cycle, burst_cnt=0, err_addr=0.

Source files
------------

// File: rtl/sim_mem_pkg.sv
// Shared types and helpers for the simulation memory arbiter.
// Holds the RAM base address, the grant encoding and the strobe-to-mask expansion.
package sim_mem_pkg;

    localparam logic [63:0] MEM_BASE = 64'h8000_0000;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_I    = 2'd1,
        GNT_D    = 2'd2
    } grant_e;

    function automatic logic [63:0] strb2mask(input logic [7:0] strb);
        logic [63:0] mask;
        mask = '0;
        for (int b = 0; b < 8; b++) begin
            mask[8*b +: 8] = {8{strb[b]}};
        end
        return mask;
    endfunction

endpackage

// File: rtl/sim_mem_arbiter_if.sv
// Bundle of icache/dcache command-response channels plus the shared RAM port.
// slave = arbiter side, master = core + RAM model side.
interface sim_mem_arbiter_if #(
    parameter int IDX_W = 28
);
    logic             i_cmd_valid;
    logic             i_cmd_ready;
    logic [63:0]      i_cmd_addr;
    logic             i_rsp_valid;
    logic [31:0]      i_rsp_data;

    logic             d_cmd_valid;
    logic             d_cmd_ready;
    logic [63:0]      d_cmd_addr;
    logic             d_cmd_wen;
    logic [63:0]      d_cmd_wdata;
    logic [7:0]       d_cmd_wstrb;
    logic [2:0]       d_cmd_size;
    logic             d_rsp_valid;
    logic [63:0]      d_rsp_data;

    logic             ram_en;
    logic [IDX_W-1:0] ram_idx;
    logic [63:0]      ram_rdata;
    logic [63:0]      ram_wdata;
    logic [63:0]      ram_wmask;
    logic             ram_wen;

    logic             err_addr;

    modport slave (
        input  i_cmd_valid, i_cmd_addr,
        output i_cmd_ready, i_rsp_valid, i_rsp_data,
        input  d_cmd_valid, d_cmd_addr, d_cmd_wen, d_cmd_wdata, d_cmd_wstrb, d_cmd_size,
        output d_cmd_ready, d_rsp_valid, d_rsp_data,
        output ram_en, ram_idx, ram_wdata, ram_wmask, ram_wen,
        input  ram_rdata,
        output err_addr
    );

    modport master (
        output i_cmd_valid, i_cmd_addr,
        input  i_cmd_ready, i_rsp_valid, i_rsp_data,
        output d_cmd_valid, d_cmd_addr, d_cmd_wen, d_cmd_wdata, d_cmd_wstrb, d_cmd_size,
        input  d_cmd_ready, d_rsp_valid, d_rsp_data,
        input  ram_en, ram_idx, ram_wdata, ram_wmask, ram_wen,
        output ram_rdata,
        input  err_addr
    );

endinterface

// File: rtl/sim_mem_grant.sv
// Two-way icache/dcache arbiter: dcache wins ties until it has taken MAX_D_BURST
// consecutive grants while icache waits, then icache gets one slot.
module sim_mem_grant
    import sim_mem_pkg::*;
#(
    parameter int MAX_D_BURST = 4
) (
    input  logic   clock,
    input  logic   reset,
    input  logic   i_valid,
    input  logic   d_valid,
    output grant_e grant
);
    localparam int CW = $clog2(MAX_D_BURST + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_D_BURST);

    logic [CW-1:0] burst_cnt, burst_cnt_nxt;
    grant_e        last_grant, last_grant_nxt;

    always_ff @(posedge clock) begin
        if (reset) begin
            burst_cnt  <= '0;
            last_grant <= GNT_D;
        end else begin
            burst_cnt  <= burst_cnt_nxt;
            last_grant <= last_grant_nxt;
        end
    end

    always_comb begin
        grant          = GNT_NONE;
        burst_cnt_nxt  = burst_cnt;
        last_grant_nxt = last_grant;
        if (!reset) begin
            if (d_valid && !(i_valid && burst_cnt == CNT_MAX)) grant = GNT_D;
            else if (i_valid)                                   grant = GNT_I;
        end
        case (grant)
            GNT_I: begin
                burst_cnt_nxt  = '0;
                last_grant_nxt = GNT_I;
            end
            GNT_D: begin
                last_grant_nxt = GNT_D;
                // A D grant right after an I grant starts a fresh burst at 1.
                if (!i_valid)                 burst_cnt_nxt = '0;
                else if (last_grant == GNT_I) burst_cnt_nxt = CW'(1);
                else if (burst_cnt != CNT_MAX) burst_cnt_nxt = burst_cnt + CW'(1);
            end
            default: burst_cnt_nxt = '0;
        endcase
    end

endmodule

// File: rtl/sim_mem_arbiter.sv
// Shares one RAMHelper port between icache and dcache: grants one command per cycle,
// maps byte addresses to word indices and returns read data one cycle later.
module sim_mem_arbiter
    import sim_mem_pkg::*;
#(
    parameter int IDX_W       = 28,
    parameter int MAX_D_BURST = 4
) (
    input  logic              clock,
    input  logic              reset,
    sim_mem_arbiter_if.slave  bus
);
    grant_e      gnt;
    logic [63:0] sel_addr, offset, rd_word;
    logic        in_range, wr;

    sim_mem_grant #(.MAX_D_BURST(MAX_D_BURST)) u_grant (
        .clock   (clock),
        .reset   (reset),
        .i_valid (bus.i_cmd_valid),
        .d_valid (bus.d_cmd_valid),
        .grant   (gnt)
    );

    assign sel_addr = (gnt == GNT_I) ? bus.i_cmd_addr : bus.d_cmd_addr;
    assign in_range = sel_addr >= MEM_BASE;
    assign offset   = sel_addr - MEM_BASE;
    assign wr       = bus.ram_en && (gnt == GNT_D) && bus.d_cmd_wen;
    // Out-of-range reads still complete, but return zero instead of RAM contents.
    assign rd_word  = in_range ? bus.ram_rdata : '0;

    assign bus.i_cmd_ready = (gnt == GNT_I);
    assign bus.d_cmd_ready = (gnt == GNT_D);
    assign bus.ram_en      = (gnt != GNT_NONE) && in_range;
    assign bus.ram_idx     = bus.ram_en ? offset[IDX_W+2:3] : '0;
    assign bus.ram_wen     = wr;
    assign bus.ram_wdata   = wr ? bus.d_cmd_wdata : '0;
    assign bus.ram_wmask   = wr ? strb2mask(bus.d_cmd_wstrb) : '0;

    always_ff @(posedge clock) begin
        if (reset) begin
            bus.i_rsp_valid <= 1'b0;
            bus.i_rsp_data  <= '0;
            bus.d_rsp_valid <= 1'b0;
            bus.d_rsp_data  <= '0;
            bus.err_addr    <= 1'b0;
        end else begin
            bus.i_rsp_valid <= (gnt == GNT_I);
            bus.d_rsp_valid <= (gnt == GNT_D) && !bus.d_cmd_wen;
            if (gnt == GNT_I)
                bus.i_rsp_data <= bus.i_cmd_addr[2] ? rd_word[63:32] : rd_word[31:0];
            if (gnt == GNT_D && !bus.d_cmd_wen)
                bus.d_rsp_data <= rd_word;
            if (gnt != GNT_NONE && !in_range)
                bus.err_addr <= 1'b1;
        end
    end

endmodule

// File: tb/tb_sim_mem_arbiter.sv
// Directed bench: stimulus pushes expected responses into queues, a negedge monitor
// pops and compares them whenever a response valid is seen.
module tb_sim_mem_arbiter;
    logic clock = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   failures = 0;
    bit   done = 1'b0;

    logic [31:0] iq[$];
    logic [63:0] dq[$];

    sim_mem_arbiter_if #(.IDX_W(28)) bus ();

    sim_mem_arbiter #(.IDX_W(28), .MAX_D_BURST(4)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        bus.i_cmd_valid = 1'b0;
        bus.d_cmd_valid = 1'b0;
        bus.d_cmd_wen   = 1'b0;
    endtask

    always @(negedge clock) begin
        if (!done) begin
            if (bus.i_rsp_valid) begin
                if (iq.size() == 0) chk("i_rsp_unexpected", 64'd1, 64'd0);
                else chk("i_rsp_data", {32'd0, bus.i_rsp_data}, {32'd0, iq.pop_front()});
            end
            if (bus.d_rsp_valid) begin
                if (dq.size() == 0) chk("d_rsp_unexpected", 64'd1, 64'd0);
                else chk("d_rsp_data", bus.d_rsp_data, dq.pop_front());
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        string seq;
        logic  exp_d;
        bus.i_cmd_valid = 1'b1;
        bus.i_cmd_addr  = 64'h8000_0000;
        bus.d_cmd_valid = 1'b0;
        bus.d_cmd_addr  = '0;
        bus.d_cmd_wen   = 1'b0;
        bus.d_cmd_wdata = '0;
        bus.d_cmd_wstrb = '0;
        bus.d_cmd_size  = 3'd3;
        bus.ram_rdata   = '0;

        // Reset: outputs low even with a request pending
        step(); step();
        #1;
        chk("rst_i_ready", {63'd0, bus.i_cmd_ready}, 64'd0);
        chk("rst_ram_en", {63'd0, bus.ram_en}, 64'd0);
        chk("rst_i_rsp_valid", {63'd0, bus.i_rsp_valid}, 64'd0);
        chk("rst_err_addr", {63'd0, bus.err_addr}, 64'd0);
        idle();
        reset = 1'b0;

        // 1: icache read, upper half
        step();
        bus.i_cmd_valid = 1'b1;
        bus.i_cmd_addr  = 64'h8000_0004;
        bus.ram_rdata   = 64'hAAAA_BBBB_CCCC_DDDD;
        #1;
        chk("t1_i_ready", {63'd0, bus.i_cmd_ready}, 64'd1);
        chk("t1_ram_en", {63'd0, bus.ram_en}, 64'd1);
        chk("t1_ram_idx", {36'd0, bus.ram_idx}, 64'd0);
        chk("t1_ram_wen", {63'd0, bus.ram_wen}, 64'd0);
        iq.push_back(32'hAAAA_BBBB);
        step();
        idle();
        #1;
        chk("t1_i_rsp_valid", {63'd0, bus.i_rsp_valid}, 64'd1);

        // 2: dcache store
        step();
        bus.d_cmd_valid = 1'b1;
        bus.d_cmd_wen   = 1'b1;
        bus.d_cmd_addr  = 64'h8000_0010;
        bus.d_cmd_wstrb = 8'h0F;
        bus.d_cmd_wdata = 64'h1122_3344_5566_7788;
        #1;
        chk("t2_d_ready", {63'd0, bus.d_cmd_ready}, 64'd1);
        chk("t2_ram_wen", {63'd0, bus.ram_wen}, 64'd1);
        chk("t2_ram_idx", {36'd0, bus.ram_idx}, 64'd2);
        chk("t2_ram_wmask", bus.ram_wmask, 64'h0000_0000_FFFF_FFFF);
        chk("t2_ram_wdata", bus.ram_wdata, 64'h1122_3344_5566_7788);
        step();
        idle();
        #1;
        chk("t2_no_d_rsp", {63'd0, bus.d_rsp_valid}, 64'd0);

        // 3: both valid continuously -> D burst of 4 then one I
        seq = "DDDDIDDDDI";
        for (int k = 0; k < 10; k++) begin
            step();
            bus.i_cmd_valid = 1'b1;
            bus.i_cmd_addr  = 64'h8000_0000;
            bus.d_cmd_valid = 1'b1;
            bus.d_cmd_wen   = 1'b0;
            bus.d_cmd_addr  = 64'h8000_0008;
            bus.ram_rdata   = {32'h1000_0000 + k, 32'h2000_0000 + k};
            #1;
            exp_d = (seq[k] == "D");
            chk("t3_d_ready", {63'd0, bus.d_cmd_ready}, {63'd0, exp_d});
            chk("t3_i_ready", {63'd0, bus.i_cmd_ready}, {63'd0, !exp_d});
            if (exp_d) dq.push_back({32'h1000_0000 + k, 32'h2000_0000 + k});
            else       iq.push_back(32'h2000_0000 + k);
        end
        step();
        idle();

        // 4: back-to-back loads
        step();
        bus.d_cmd_valid = 1'b1;
        bus.d_cmd_addr  = 64'h8000_0000;
        bus.ram_rdata   = 64'h0123_4567_89AB_CDEF;
        #1;
        chk("t4_idx0", {36'd0, bus.ram_idx}, 64'd0);
        dq.push_back(64'h0123_4567_89AB_CDEF);
        step();
        bus.d_cmd_addr = 64'h8000_0008;
        bus.ram_rdata  = 64'hFEDC_BA98_7654_3210;
        #1;
        chk("t4_idx1", {36'd0, bus.ram_idx}, 64'd1);
        chk("t4_rsp_valid_1", {63'd0, bus.d_rsp_valid}, 64'd1);
        dq.push_back(64'hFEDC_BA98_7654_3210);
        step();
        idle();
        #1;
        chk("t4_rsp_valid_2", {63'd0, bus.d_rsp_valid}, 64'd1);
        step();
        chk("t4_rsp_valid_end", {63'd0, bus.d_rsp_valid}, 64'd0);

        // 5: load below MEM_BASE
        step();
        bus.d_cmd_valid = 1'b1;
        bus.d_cmd_addr  = 64'h7FFF_FFF8;
        bus.ram_rdata   = 64'hDEAD_BEEF_DEAD_BEEF;
        #1;
        chk("t5_d_ready", {63'd0, bus.d_cmd_ready}, 64'd1);
        chk("t5_ram_en", {63'd0, bus.ram_en}, 64'd0);
        dq.push_back(64'd0);
        step();
        idle();
        #1;
        chk("t5_err_set", {63'd0, bus.err_addr}, 64'd1);
        step(); step(); step();
        chk("t5_err_sticky", {63'd0, bus.err_addr}, 64'd1);

        // 6a: reset mid-burst clears burst_cnt, err_addr and pending responses
        for (int k = 0; k < 2; k++) begin
            step();
            bus.i_cmd_valid = 1'b1;
            bus.i_cmd_addr  = 64'h8000_0000;
            bus.d_cmd_valid = 1'b1;
            bus.d_cmd_addr  = 64'h8000_0008;
            bus.ram_rdata   = 64'h5500_0000_0000_0000 + k;
            #1;
            chk("t6_pre_d_ready", {63'd0, bus.d_cmd_ready}, 64'd1);
            dq.push_back(64'h5500_0000_0000_0000 + k);
        end
        step();
        reset = 1'b1;
        #1;
        chk("t6_rst_d_ready", {63'd0, bus.d_cmd_ready}, 64'd0);
        chk("t6_rst_ram_en", {63'd0, bus.ram_en}, 64'd0);
        seq = "DDDDI";
        for (int k = 0; k < 5; k++) begin
            step();
            reset = 1'b0;
            bus.ram_rdata = {32'h6600_0000 + k, 32'h7700_0000 + k};
            #1;
            if (k == 0) begin
                chk("t6_d_rsp_dropped", {63'd0, bus.d_rsp_valid}, 64'd0);
                chk("t6_err_cleared", {63'd0, bus.err_addr}, 64'd0);
            end
            exp_d = (seq[k] == "D");
            chk("t6_d_ready", {63'd0, bus.d_cmd_ready}, {63'd0, exp_d});
            chk("t6_i_ready", {63'd0, bus.i_cmd_ready}, {63'd0, !exp_d});
            if (exp_d) dq.push_back({32'h6600_0000 + k, 32'h7700_0000 + k});
            else       iq.push_back(32'h7700_0000 + k);
        end
        step();
        idle();
        step();

        // 6b: reset the cycle after an i grant
        step();
        bus.i_cmd_valid = 1'b1;
        bus.i_cmd_addr  = 64'h8000_000C;
        bus.ram_rdata   = 64'h1357_9BDF_2468_ACE0;
        #1;
        chk("t6b_i_ready", {63'd0, bus.i_cmd_ready}, 64'd1);
        iq.push_back(32'h1357_9BDF);
        step();
        idle();
        reset = 1'b1;
        #1;
        chk("t6b_i_rsp_before_rst", {63'd0, bus.i_rsp_valid}, 64'd1);
        step();
        reset = 1'b0;
        #1;
        chk("t6b_i_rsp_dropped", {63'd0, bus.i_rsp_valid}, 64'd0);
        chk("t6b_err_addr", {63'd0, bus.err_addr}, 64'd0);

        step(); step();
        chk("iq_drained", 64'(iq.size()), 64'd0);
        chk("dq_drained", 64'(dq.size()), 64'd0);
        done = 1'b1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
